// File: rtl/vend_payout_sched_pkg.sv
// Shared types for the payout scheduler.
//   act_sel_t     : actuator select code driven on ACT_SEL (0=ticket, 1=coin0, 2=coin1)
//   award_t       : one award event {t, c0, c1}; t is the MSB, so it matches {T_IN,C0_IN,C1_IN}
//   sched_state_t : scheduler FSM states
// Helpers choose the next actuator for a pending award and retire a serviced bit.
package vend_payout_sched_pkg;

  typedef enum logic [1:0] {
    ACT_TKT = 2'd0,
    ACT_C0  = 2'd1,
    ACT_C1  = 2'd2
  } act_sel_t;

  typedef struct packed {
    logic t;
    logic c0;
    logic c1;
  } award_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_REL,
    S_FAULT
  } sched_state_t;

  // Ticket first, then coin0, then coin1. Bits that are clear are skipped outright.
  // The caller guarantees that a is non-zero.
  function automatic act_sel_t first_award(input award_t a);
    if (a.t)       return ACT_TKT;
    else if (a.c0) return ACT_C0;
    else           return ACT_C1;
  endfunction

  function automatic award_t clear_award(input award_t a, input act_sel_t s);
    award_t r;
    r = a;
    case (s)
      ACT_TKT: r.t  = 1'b0;
      ACT_C0:  r.c0 = 1'b0;
      default: r.c1 = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vend_payout_sched_payout_fifo.sv
// payout_fifo: a small synchronous FIFO of award_t events.
//   CLK, RESET      clock and synchronous active-high reset (empties the FIFO)
//   push, din       write request and data; the write is accepted when not full, or when a
//                   pop happens in the same cycle
//   pop             read request; it is ignored while the FIFO is empty
//   dout            head entry (combinational view of the read pointer)
//   full, empty     occupancy flags
// Pointers are log2(DEPTH) bits wide and wrap naturally. The occupancy counter carries one
// extra bit so that full and empty can be told apart.
module payout_fifo
  import vend_payout_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   push,
  input  award_t din,
  input  logic   pop,
  output award_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  award_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // The storage array has no reset; only entries covered by the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vend_payout_sched.sv
// vend_payout_sched: buffers {T,C0,C1} award events and runs them one at a time on a single
// shared actuator driver, using a req/ack handshake with a timeout fault.
// Ports:
//   CLK, RESET              clock and synchronous active-high reset
//   EV_VALID, T_IN/C0_IN/C1_IN  award event strobe and award bits; an all-zero event is ignored
//   FULL, OVERFLOW          FIFO full; sticky "event dropped" flag
//   ACT_REQ, ACT_SEL        actuator request and select (0=ticket 1=coin0 2=coin1)
//   ACT_ACK                 actuator done (level); it must drop before the next request
//   BUSY                    work outstanding (FSM active, an event pending, or FIFO non-empty)
//   FAULT, FAULT_CLR        sticky timeout fault; FAULT_CLR clears FAULT and OVERFLOW
// Build option: define VEND_PAYOUT_LOG_EN to add the payout counters TKT_CNT/C0_CNT/C1_CNT.
module vend_payout_sched
  import vend_payout_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EV_VALID,
  input  logic             T_IN,
  input  logic             C0_IN,
  input  logic             C1_IN,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic             ACT_REQ,
  output logic [1:0]       ACT_SEL,
  input  logic             ACT_ACK,
  output logic             BUSY,
  output logic             FAULT,
  input  logic             FAULT_CLR
`ifdef VEND_PAYOUT_LOG_EN
  ,
  output logic [CNT_W-1:0] TKT_CNT,
  output logic [CNT_W-1:0] C0_CNT,
  output logic [CNT_W-1:0] C1_CNT
`endif
);

  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  // Reject bad parameter values at elaboration time.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_width
    $error("CNT_W and TIMEOUT_CYC must be >= 1");
  end

  sched_state_t  state;
  award_t        pend;
  award_t        ev;
  award_t        fifo_dout;
  act_sel_t      act_sel;
  logic [TW-1:0] timer;
  logic          fifo_full, fifo_empty;
  logic          push, pop, drop;

  assign ev   = '{t: T_IN, c0: C0_IN, c1: C1_IN};
  assign push = EV_VALID && (ev != '0);

  // Only fetch a new event once the current one is fully serviced: from IDLE, or on the
  // release cycle that ends the last payout of an event.
  assign pop  = !fifo_empty && (pend == '0) &&
                ((state == S_IDLE) || (state == S_WAIT_REL && !ACT_ACK));
  assign drop = push && fifo_full && !pop;

  payout_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .din   (ev),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign FULL    = fifo_full;
  assign ACT_SEL = act_sel;
  // An event that has been popped but not yet dispatched still counts as work in hand.
  assign BUSY    = (state != S_IDLE) || (pend != '0) || !fifo_empty;

`ifdef VEND_PAYOUT_LOG_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      TKT_CNT <= '0;
      C0_CNT  <= '0;
      C1_CNT  <= '0;
    end else if (state == S_REQ && ACT_ACK) begin
      case (act_sel)
        ACT_TKT: TKT_CNT <= TKT_CNT + 1'b1;
        ACT_C0:  C0_CNT  <= C0_CNT + 1'b1;
        default: C1_CNT  <= C1_CNT + 1'b1;
      endcase
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      pend     <= '0;
      act_sel  <= ACT_TKT;
      ACT_REQ  <= 1'b0;
      timer    <= '0;
      FAULT    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      // If an event is dropped in the same cycle as a clear, the new drop is still recorded.
      if (drop)           OVERFLOW <= 1'b1;
      else if (FAULT_CLR) OVERFLOW <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pend != '0) begin
            state   <= S_REQ;
            ACT_REQ <= 1'b1;
            act_sel <= first_award(pend);
            timer   <= '0;
          end else if (pop) begin
            pend <= fifo_dout;
          end
        end

        S_REQ: begin
          // When ACK arrives on the timeout cycle, the ACK takes priority and no fault is raised.
          if (ACT_ACK) begin
            ACT_REQ <= 1'b0;
            pend    <= clear_award(pend, act_sel);
            state   <= S_WAIT_REL;
          end else if (timer == TMR_LAST) begin
            ACT_REQ <= 1'b0;
            FAULT   <= 1'b1;
            state   <= S_FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_WAIT_REL: begin
          if (!ACT_ACK) begin
            if (pend != '0) begin
              state   <= S_REQ;
              ACT_REQ <= 1'b1;
              act_sel <= first_award(pend);
              timer   <= '0;
            end else begin
              state <= S_IDLE;
              if (pop) pend <= fifo_dout;
            end
          end
        end

        default: begin  // S_FAULT: hold until cleared; the faulted event is abandoned
          if (FAULT_CLR) begin
            state <= S_IDLE;
            FAULT <= 1'b0;
            pend  <= '0;
          end
        end
      endcase
    end
  end

endmodule
